uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_tx_serializer.sv | 148 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit state encoding and default bit period
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte offer handshake between a producer and the UART transmitter
interface uart_tx_serializer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16-bit bit-period down-counter, tick while the count sits at zero
module uart_baud_tick (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_i,
  input  logic [15:0] load_value_i,
  output logic        tick_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != 16'd0) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == 16'd0);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART byte serializer: start, 8 data bits LSB first, optional parity, stop
// Parity bit is built in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_serializer_if.slave  s_if,
  output logic                 TX,
  output logic                 BUSY
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1)
  begin : g_bad_param
    $error("uart_tx_serializer: illegal parameter value");
  end

  localparam logic [15:0] RELOAD    = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       load;
  logic       tick;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  uart_baud_tick u_baud_tick (
    .CLK          (CLK),
    .RST          (RST),
    .load_i       (load),
    .load_value_i (RELOAD),
    .tick_o       (tick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      shift_q <= 8'd0;
      idx_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (s_if.tx_valid) state_d = START;
      START:  if (tick) state_d = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (tick && idx_q == 3'd7) state_d = PARITY;
      PARITY: if (tick) state_d = STOP;
`else
      DATA:   if (tick && idx_q == 3'd7) state_d = STOP;
`endif
      STOP:   if (tick && idx_q == LAST_STOP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register drains LSB first; parity is latched at accept so it survives the drain.
  always_comb begin
    tx_d    = tx_q;
    ready_d = ready_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: if (s_if.tx_valid) begin
        shift_d = s_if.tx_data;
        tx_d    = 1'b0;
        ready_d = 1'b0;
        idx_d   = 3'd0;
        load    = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d = (^s_if.tx_data) ^ PARITY_ODD[0];
`endif
      end
      START: if (tick) begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        load    = 1'b1;
      end
      DATA: if (tick) begin
        load = 1'b1;
        if (idx_q == 3'd7) begin
          idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          tx_d = parity_q;
`else
          tx_d = 1'b1;
`endif
        end else begin
          idx_d   = idx_q + 3'd1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        tx_d = 1'b1;
        load = 1'b1;
      end
`endif
      STOP: if (tick) begin
        if (idx_q == LAST_STOP) begin
          idx_d   = 3'd0;
          ready_d = 1'b1;
          shift_d = 8'd0;
        end else begin
          idx_d = idx_q + 3'd1;
          load  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign TX            = tx_q;
  assign s_if.tx_ready = ready_q;
  assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed frame checks on two serializer instances (1 and 2 stop bits)
module tb_uart_tx_serializer;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic tx_a, busy_a, tx_b, busy_b;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  uart_tx_serializer_if a_if ();
  uart_tx_serializer_if b_if ();

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .CLK (CLK), .RST (RST), .s_if (a_if), .TX (tx_a), .BUSY (busy_a)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .CLK (CLK), .RST (RST), .s_if (b_if), .TX (tx_b), .BUSY (busy_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? a_if.tx_ready : b_if.tx_ready;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin
      a_if.tx_valid = v;
      a_if.tx_data  = d;
    end else begin
      b_if.tx_valid = v;
      b_if.tx_data  = d;
    end
  endtask

  // Pulse valid once, then walk the whole frame cycle by cycle; optionally offer 8'hFF mid-frame.
  task automatic frame_check(input int w, input logic [7:0] d, input logic par,
                             input int inject_at, input string tag);
    int   stops;
    int   nbits;
    int   cyc;
    logic exp;
    stops = (w == 0) ? 1 : 2;
    nbits = 9 + P + stops;
    cyc   = 0;
    drive(w, 1'b1, d);
    @(posedge CLK); #1;
    drive(w, 1'b0, ~d);
    check_val({tag, "_busy_hi"}, 32'(get_busy(w)), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < C; j++) begin
        if (b == 0) exp = 1'b0;
        else if (b <= 8) exp = d[b-1];
        else if (P == 1 && b == 9) exp = par;
        else exp = 1'b1;
        check_val($sformatf("%s_bit%0d_c%0d", tag, b, j), 32'(get_tx(w)), 32'(exp));
        check_val($sformatf("%s_rdy_lo_c%0d", tag, cyc), 32'(get_ready(w)), 32'd0);
        if (cyc == inject_at) drive(w, 1'b1, 8'hFF);
        else if (cyc == inject_at + 1) drive(w, 1'b0, 8'hFF);
        cyc++;
        @(posedge CLK); #1;
      end
    end
    check_val({tag, "_rdy_hi_end"}, 32'(get_ready(w)), 32'd1);
    check_val({tag, "_busy_lo_end"}, 32'(get_busy(w)), 32'd0);
    check_val({tag, "_tx_idle_end"}, 32'(get_tx(w)), 32'd1);
  endtask

  logic [7:0] b_bytes [4] = '{8'h55, 8'h81, 8'h07, 8'hE7};
  logic       b_par   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    for (int w = 0; w < 2; w++) begin
      check_val($sformatf("rst_tx_%0d", w), 32'(get_tx(w)), 32'd1);
      check_val($sformatf("rst_rdy_%0d", w), 32'(get_ready(w)), 32'd1);
      check_val($sformatf("rst_busy_%0d", w), 32'(get_busy(w)), 32'd0);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    check_val("idle_rdy", 32'(get_ready(0)), 32'd1);

    frame_check(0, 8'hA5, 1'b0, -1, "a5");
    frame_check(0, 8'h07, 1'b1, -1, "p07_even");
    frame_check(0, 8'h00, 1'b0, 12, "ignore_ff");
    for (int i = 0; i < 2 * C; i++) begin
      check_val($sformatf("no_ff_tx_c%0d", i), 32'(get_tx(0)), 32'd1);
      check_val($sformatf("no_ff_busy_c%0d", i), 32'(get_busy(0)), 32'd0);
      @(posedge CLK); #1;
    end

    drive(0, 1'b1, 8'h5A);
    @(posedge CLK); #1;
    drive(0, 1'b0, 8'h00);
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check_val("midrst_tx", 32'(get_tx(0)), 32'd1);
    check_val("midrst_rdy", 32'(get_ready(0)), 32'd1);
    check_val("midrst_busy", 32'(get_busy(0)), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    frame_check(0, 8'h3C, 1'b0, -1, "after_rst_3c");

    for (int i = 0; i < 4; i++) begin
      frame_check(1, b_bytes[i], b_par[i], -1, $sformatf("stop2_byte%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
